// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter slice.
//   arb_state_t : arbiter FSM state encoding
//   *_DEF       : default parameter values for mem_arbiter
//   idx_width() : width of a binary index able to address n requesters
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam int N_REQ_DEF      = 4;
   localparam int TIMEOUT_DEF    = 15;
   localparam int WIDTH_DEF      = 8;
   localparam int ADDR_WIDTH_DEF = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : index of the most recently granted requester
//   grant : one-hot winner, first set req bit searching upward from last+1 (wrapping)
//   idx   : binary index of the winner (0 when no request)
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int LW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [LW-1:0]    last,
   output logic [N_REQ-1:0] grant,
   output logic [LW-1:0]    idx
);

   int   pos;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      // k = N_REQ lands back on last itself, so a lone requester is re-granted
      for (int k = 1; k <= N_REQ; k++) begin
         pos = (int'(last) + k) % N_REQ;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = LW'(pos);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among N_REQ requesters.
// One command is latched at a time, issued as a one-cycle mem_valid pulse,
// and completed with a done pulse to the winner when mem_ready arrives, or
// with done+err if memory stays silent for TIMEOUT cycles.
//   clk, rst                         : clock, synchronous active-high reset
//   req/req_wr_rd/req_addr/req_wdata : per-requester command (packed by index)
//   gnt, done, err                   : one-hot grant / completion pulses, timeout flag
//   rdata                            : read data, held until the next read completes
//   mem_*                            : memory command/response port
//
// state | meaning
// IDLE  | arbitrate; on any request latch winner's command and raise mem_valid
// ISSUE | mem_valid high this cycle; clear timeout counter
// WAIT  | wait for mem_ready, or abort with err after TIMEOUT cycles
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_REQ      = N_REQ_DEF,
   parameter int WIDTH      = WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ-1:0]            req_wr_rd,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*WIDTH-1:0]      req_wdata,
   output logic [N_REQ-1:0]            gnt,
   output logic [N_REQ-1:0]            done,
   output logic                        err,
   output logic [WIDTH-1:0]            rdata,
   output logic                        mem_valid,
   output logic                        mem_wr_rd,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [WIDTH-1:0]            mem_wdata,
   input  logic                        mem_ready,
   input  logic [WIDTH-1:0]            mem_rdata
);

   localparam int LW    = idx_width(N_REQ);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   arb_state_t              state, state_nxt;
   logic [LW-1:0]           last, last_nxt;
   logic [TMO_W-1:0]        tmo, tmo_nxt;
   logic [N_REQ-1:0]        gnt_nxt, done_nxt;
   logic                    err_nxt, mem_valid_nxt, mem_wr_rd_nxt;
   logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
   logic [WIDTH-1:0]        mem_wdata_nxt, rdata_nxt;
   logic [N_REQ-1:0]        pick_grant;
   logic [LW-1:0]           pick_idx;

   rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
      .req   (req),
      .last  (last),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // last doubles as the index of the in-flight winner, so done is decoded from it
   always_comb begin
      state_nxt     = state;
      last_nxt      = last;
      tmo_nxt       = tmo;
      gnt_nxt       = '0;
      done_nxt      = '0;
      err_nxt       = 1'b0;
      mem_valid_nxt = 1'b0;
      mem_wr_rd_nxt = mem_wr_rd;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      rdata_nxt     = rdata;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_nxt       = pick_grant;
               last_nxt      = pick_idx;
               mem_wr_rd_nxt = req_wr_rd[pick_idx];
               mem_addr_nxt  = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               mem_wdata_nxt = req_wdata[int'(pick_idx)*WIDTH +: WIDTH];
               mem_valid_nxt = 1'b1;
               state_nxt     = ISSUE;
            end
         end
         ISSUE: begin
            tmo_nxt   = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_ready) begin
               done_nxt  = N_REQ'(1) << last;
               if (!mem_wr_rd) rdata_nxt = mem_rdata;
               state_nxt = IDLE;
            end else begin
               tmo_nxt = tmo + TMO_W'(1);
               if (tmo == TMO_W'(TIMEOUT - 1)) begin
                  done_nxt  = N_REQ'(1) << last;
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= LW'(N_REQ - 1);
         tmo       <= '0;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         mem_valid <= 1'b0;
         mem_wr_rd <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         tmo       <= tmo_nxt;
         gnt       <= gnt_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         mem_valid <= mem_valid_nxt;
         mem_wr_rd <= mem_wr_rd_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         rdata     <= rdata_nxt;
      end
   end

endmodule
